nn_out_collector: RTL and testbench
===================================

// Module: nn_out_collector
// PURPOSE
//   Sits directly downstream of the 2-lane NN top. Captures the per-lane activation outputs
//   (nn_data_out_1/2 with nn_valid_out_1/2), deskews lane 2 (one cycle behind lane 1 from the
//   systolic skew), packs each lane pair into one word and buffers it in a FIFO drained by a
//   valid/ready reader (host/testbench/writeback).
// PARAMETERS
//   DATA_W  16  width of one lane sample (signed Q8.8 fixed point, carried as raw bits)
//   DEPTH   8   FIFO entries; power of two, >= 2
// PORTS
//   clk            in   1           clock; all logic on rising edge
//   rst            in   1           synchronous, active-high reset
//   col_data_in_1  in   DATA_W      lane-1 sample (from nn_data_out_1)
//   col_valid_in_1 in   1           lane-1 sample valid
//   col_data_in_2  in   DATA_W      lane-2 sample (from nn_data_out_2)
//   col_valid_in_2 in   1           lane-2 sample valid
//   col_clear      in   1           synchronous flush of skew slot, FIFO and sticky flags
//   col_data_out   out  2*DATA_W    head word {lane2, lane1}
//   col_valid_out  out  1           head word valid (= FIFO not empty)
//   col_ready_in   in   1           reader accepts head word this cycle
//   col_count      out  $clog2(DEPTH)+1  words currently stored
//   col_full       out  1           count == DEPTH
//   col_overflow   out  1           sticky: a pair was dropped because the FIFO was full
//   col_pair_err   out  1           sticky: an unpaired lane sample was seen
// BEHAVIOUR
//   Reset: slot EMPTY, FIFO empty, col_data_out=0, col_valid_out=0, col_count=0,
//   col_full=0, col_overflow=0, col_pair_err=0.
//   Skew slot FSM {EMPTY, HELD}, holds one lane-1 sample. Per cycle (v1/v2 = valid_in_1/2):
//   - EMPTY, v1 & !v2: slot<=d1 -> HELD. No push.
//   - EMPTY, v1 & v2 : push {d2,d1}; stay EMPTY.
//   - EMPTY, !v1 & v2: push {d2,16'h0}; set pair_err; stay EMPTY.
//   - HELD,  v2      : push {d2,slot}; if v1 then slot<=d1 stay HELD, else -> EMPTY.
//   - HELD,  v1 & !v2: orphan; push {16'h0,slot}; set pair_err; slot<=d1, stay HELD.
//   - no valids: no change.
//   FIFO: first-word-fall-through. Pop when col_valid_out & col_ready_in. Push in cycle N is
//   visible on col_data_out/col_valid_out in cycle N+1 (1-cycle latency when empty).
//   - Push while full and no pop: word dropped, contents unchanged, set col_overflow.
//   - Push and pop in the same cycle while full: both happen, count stays DEPTH, no drop.
//   - Pop while empty: ignored (col_ready_in is don't-care when col_valid_out=0).
//   - Pointers wrap modulo DEPTH; count is the only full/empty source.
//   col_clear: has priority over push/pop. Same cycle: slot->EMPTY, FIFO emptied, stickies
//   cleared, inputs that cycle discarded. rst mid-operation behaves like col_clear.
//   Data is packed bit-exact; no arithmetic, sign extension or saturation.
// CONFIGURATION
//   NN_OUT_COLLECT_DROP_CNT_EN: defined -> extra output port
//     col_drop_cnt out 16 = count of dropped words. Saturates at 16'hFFFF. Cleared by
//     rst/col_clear.
//   Undefined -> port and counter absent. Overflow is reported only by the sticky
//   col_overflow.
// STRUCTURE
//   nn_out_pkg: typedef enum logic {SLOT_EMPTY, SLOT_HELD} slot_state_t;
//     typedef struct packed {logic [15:0] lane2, lane1;} nn_pair_t (DATA_W=16 build).
//   Sub-module nn_out_fifo (sync FWFT FIFO, push/pop/clear, count/full/empty).
//   The skew FSM and sticky flags stay in nn_out_collector.
// TESTING
//   1. Aligned stream: v1 with d1=0x0100 at cycle 0, v2 with d2=0xFF80 at cycle 1, ready=1
//      -> col_data_out=0xFF800100, valid at cycle 2 only; pair_err=0.
//   2. Back-to-back: v1 at cycles 0-3 and v2 at cycles 1-4, values 1..4 / 11..14, ready=0
//      -> count=4, pops give {11,1},{12,2},{13,3},{14,4}.
//   3. Fill DEPTH=8 pairs with ready=0, push a 9th -> full=1, overflow=1, 9th dropped,
//      drop_cnt=1 with macro. Then push+pop in the same cycle while full -> count stays 8,
//      no new drop.
//   4. Orphans: v1=5 then v1=6 with no v2 -> push {0,5}, pair_err=1. Later v2=0x20
//      -> push {0x20,6}.
//   5. Lone v2=0x33 with slot EMPTY -> push {0x33,0}, pair_err=1.
//      Simultaneous v1=7,v2=8 from EMPTY -> push {8,7}.
//   6. col_clear asserted with 3 words stored, slot HELD and v1/v2 active
//      -> next cycle count=0, valid_out=0, flags 0, nothing pushed.
//      Repeat with rst -> identical state.

Source files
------------

// File: rtl/nn_out_pkg.sv
// Shared types for the NN output collector: skew-slot state and packed lane pair.
package nn_out_pkg;

    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_HELD = 1'b1} slot_state_t;

    localparam int unsigned LANE_W = 16;

    typedef struct packed {
        logic [LANE_W-1:0] lane2;
        logic [LANE_W-1:0] lane1;
    } nn_pair_t;

endpackage

// File: rtl/nn_out_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head word, count and full flag.
module nn_out_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       ready,
    output logic [W-1:0]               data_out,
    output logic                       valid_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       drop_c
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    rd_q, rd_nxt, wr_q, wr_nxt;
    logic [CNT_W-1:0] count_nxt, remain;
    logic [W-1:0]     head_nxt;
    logic             pop, push_ok;

    // Head word is precomputed so data_out comes straight from a flop.
    always_comb begin
        pop       = valid_out & ready;
        push_ok   = push & (~full | pop);
        drop_c    = push & full & ~pop;
        count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop);
        rd_nxt    = pop     ? rd_q + AW'(1) : rd_q;
        wr_nxt    = push_ok ? wr_q + AW'(1) : wr_q;
        remain    = count - CNT_W'(pop);
        head_nxt  = '0;
        if (remain != '0) begin
            head_nxt = mem[rd_nxt];
        end else if (push_ok) begin
            head_nxt = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_q      <= '0;
            wr_q      <= '0;
            count     <= '0;
            full      <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            rd_q      <= rd_nxt;
            wr_q      <= wr_nxt;
            count     <= count_nxt;
            full      <= (count_nxt == CNT_W'(DEPTH));
            valid_out <= (count_nxt != '0);
            data_out  <= head_nxt;
        end
    end

endmodule

// File: rtl/nn_out_collector.sv
// Deskews the two NN output lanes, packs {lane2, lane1} and buffers pairs in a FWFT FIFO.
// Optional NN_OUT_COLLECT_DROP_CNT_EN adds a saturating dropped-word counter port.
module nn_out_collector
    import nn_out_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        col_data_in_1,
    input  logic                     col_valid_in_1,
    input  logic [DATA_W-1:0]        col_data_in_2,
    input  logic                     col_valid_in_2,
    input  logic                     col_clear,
    output logic [2*DATA_W-1:0]      col_data_out,
    output logic                     col_valid_out,
    input  logic                     col_ready_in,
    output logic [$clog2(DEPTH):0]   col_count,
    output logic                     col_full,
    output logic                     col_overflow,
    output logic                     col_pair_err
`ifdef NN_OUT_COLLECT_DROP_CNT_EN
    ,
    output logic [15:0]              col_drop_cnt
`endif
);
    localparam logic [0:0] ST_EMPTY = 1'(SLOT_EMPTY);
    localparam logic [0:0] ST_HELD  = 1'(SLOT_HELD);

    logic [0:0]          state_q, state_nxt;
    logic [DATA_W-1:0]   slot_q, slot_nxt;
    logic                push_c, pair_err_set_c, drop_c;
    logic [2*DATA_W-1:0] push_data_c;

    // Skew slot: lane 1 waits here for its lane-2 partner one cycle later.
    always_ff @(posedge clk) begin
        if (rst || col_clear) begin
            state_q <= ST_EMPTY;
            slot_q  <= '0;
        end else begin
            state_q <= state_nxt;
            slot_q  <= slot_nxt;
        end
    end

    always_comb begin
        state_nxt      = state_q;
        slot_nxt       = slot_q;
        push_c         = 1'b0;
        push_data_c    = '0;
        pair_err_set_c = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (col_valid_in_1 && !col_valid_in_2) begin
                    slot_nxt  = col_data_in_1;
                    state_nxt = ST_HELD;
                end else if (col_valid_in_1 && col_valid_in_2) begin
                    push_c      = 1'b1;
                    push_data_c = {col_data_in_2, col_data_in_1};
                end else if (col_valid_in_2) begin
                    push_c         = 1'b1;
                    push_data_c    = {col_data_in_2, DATA_W'(0)};
                    pair_err_set_c = 1'b1;
                end
            end
            ST_HELD: begin
                if (col_valid_in_2) begin
                    push_c      = 1'b1;
                    push_data_c = {col_data_in_2, slot_q};
                    if (col_valid_in_1) begin
                        slot_nxt = col_data_in_1;
                    end else begin
                        state_nxt = ST_EMPTY;
                    end
                end else if (col_valid_in_1) begin
                    // Held sample never got a partner: flush it zero-padded.
                    push_c         = 1'b1;
                    push_data_c    = {DATA_W'(0), slot_q};
                    pair_err_set_c = 1'b1;
                    slot_nxt       = col_data_in_1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (col_clear) begin
            push_c         = 1'b0;
            pair_err_set_c = 1'b0;
        end
    end

    nn_out_fifo #(
        .W     (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (col_clear),
        .push      (push_c),
        .push_data (push_data_c),
        .ready     (col_ready_in),
        .data_out  (col_data_out),
        .valid_out (col_valid_out),
        .count     (col_count),
        .full      (col_full),
        .drop_c    (drop_c)
    );

    // Sticky status flags.
    always_ff @(posedge clk) begin
        if (rst || col_clear) begin
            col_overflow <= 1'b0;
            col_pair_err <= 1'b0;
        end else begin
            col_overflow <= col_overflow | drop_c;
            col_pair_err <= col_pair_err | pair_err_set_c;
        end
    end

`ifdef NN_OUT_COLLECT_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || col_clear) begin
            col_drop_cnt <= '0;
        end else if (drop_c && (col_drop_cnt != 16'hFFFF)) begin
            col_drop_cnt <= col_drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nn_out_collector.sv
// Directed self-checking bench for nn_out_collector (DATA_W=16, DEPTH=8).
module tb_nn_out_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] col_data_in_1, col_data_in_2;
    logic        col_valid_in_1, col_valid_in_2;
    logic        col_clear, col_ready_in;
    logic [31:0] col_data_out;
    logic        col_valid_out;
    logic [3:0]  col_count;
    logic        col_full, col_overflow, col_pair_err;
`ifdef NN_OUT_COLLECT_DROP_CNT_EN
    logic [15:0] col_drop_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nn_out_collector #(.DATA_W(16), .DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .col_data_in_1  (col_data_in_1),
        .col_valid_in_1 (col_valid_in_1),
        .col_data_in_2  (col_data_in_2),
        .col_valid_in_2 (col_valid_in_2),
        .col_clear      (col_clear),
        .col_data_out   (col_data_out),
        .col_valid_out  (col_valid_out),
        .col_ready_in   (col_ready_in),
        .col_count      (col_count),
        .col_full       (col_full),
        .col_overflow   (col_overflow),
        .col_pair_err   (col_pair_err)
`ifdef NN_OUT_COLLECT_DROP_CNT_EN
        ,
        .col_drop_cnt   (col_drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then settle 1 time unit past the edge for checks.
    task automatic step(input logic v1, input logic [15:0] d1, input logic v2,
                        input logic [15:0] d2, input logic rdy, input logic clr);
        col_valid_in_1 = v1;
        col_data_in_1  = d1;
        col_valid_in_2 = v2;
        col_data_in_2  = d2;
        col_ready_in   = rdy;
        col_clear      = clr;
        @(posedge clk);
        #1;
        col_valid_in_1 = 1'b0;
        col_valid_in_2 = 1'b0;
        col_clear      = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 16'h0, 1'b0, 16'h0, rdy, 1'b0);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_count"}, 32'(col_count), 32'd0);
        chk({tag, "_valid"}, 32'(col_valid_out), 32'd0);
        chk({tag, "_data"}, col_data_out, 32'h0);
        chk({tag, "_full"}, 32'(col_full), 32'd0);
        chk({tag, "_ovf"}, 32'(col_overflow), 32'd0);
        chk({tag, "_perr"}, 32'(col_pair_err), 32'd0);
`ifdef NN_OUT_COLLECT_DROP_CNT_EN
        chk({tag, "_dcnt"}, 32'(col_drop_cnt), 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        idle(1'b0);
        idle(1'b0);
        rst = 1'b0;
        chk_empty("reset");

        // 1. aligned stream, one-cycle lane skew
        step(1'b1, 16'h0100, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("t1_no_early_valid", 32'(col_valid_out), 32'd0);
        step(1'b0, 16'h0, 1'b1, 16'hFF80, 1'b1, 1'b0);
        chk("t1_valid", 32'(col_valid_out), 32'd1);
        chk("t1_data", col_data_out, 32'hFF80_0100);
        idle(1'b1);
        chk("t1_popped", 32'(col_valid_out), 32'd0);
        chk("t1_perr", 32'(col_pair_err), 32'd0);

        // 2. back-to-back skewed pairs, reader stalled
        step(1'b1, 16'd1, 1'b0, 16'd0,  1'b0, 1'b0);
        step(1'b1, 16'd2, 1'b1, 16'd11, 1'b0, 1'b0);
        step(1'b1, 16'd3, 1'b1, 16'd12, 1'b0, 1'b0);
        step(1'b1, 16'd4, 1'b1, 16'd13, 1'b0, 1'b0);
        step(1'b0, 16'd0, 1'b1, 16'd14, 1'b0, 1'b0);
        chk("t2_count", 32'(col_count), 32'd4);
        chk("t2_head0", col_data_out, {16'd11, 16'd1});
        idle(1'b1);
        chk("t2_head1", col_data_out, {16'd12, 16'd2});
        idle(1'b1);
        chk("t2_head2", col_data_out, {16'd13, 16'd3});
        idle(1'b1);
        chk("t2_head3", col_data_out, {16'd14, 16'd4});
        idle(1'b1);
        chk("t2_drained", 32'(col_valid_out), 32'd0);
        chk("t2_perr", 32'(col_pair_err), 32'd0);

        // 3. fill, overflow, then simultaneous push/pop while full
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'(i + 1), 1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
        end
        chk("t3_count8", 32'(col_count), 32'd8);
        chk("t3_full", 32'(col_full), 32'd1);
        chk("t3_no_ovf_yet", 32'(col_overflow), 32'd0);
        step(1'b1, 16'hBEEF, 1'b1, 16'hDEAD, 1'b0, 1'b0);
        chk("t3_ovf", 32'(col_overflow), 32'd1);
        chk("t3_count_after_drop", 32'(col_count), 32'd8);
        chk("t3_head_after_drop", col_data_out, 32'h0100_0001);
`ifdef NN_OUT_COLLECT_DROP_CNT_EN
        chk("t3_dcnt1", 32'(col_drop_cnt), 32'd1);
`endif
        step(1'b1, 16'h0009, 1'b1, 16'h0200, 1'b1, 1'b0);
        chk("t3_pp_count", 32'(col_count), 32'd8);
        chk("t3_pp_full", 32'(col_full), 32'd1);
`ifdef NN_OUT_COLLECT_DROP_CNT_EN
        chk("t3_pp_dcnt", 32'(col_drop_cnt), 32'd1);
`endif
        for (int i = 0; i < 8; i++) begin
            logic [31:0] exp;
            exp = (i < 7) ? {16'(16'h0100 + i + 1), 16'(i + 2)} : 32'h0200_0009;
            chk($sformatf("t3_drain%0d", i), col_data_out, exp);
            idle(1'b1);
        end
        chk("t3_drained", 32'(col_valid_out), 32'd0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("t3_clear_ovf", 32'(col_overflow), 32'd0);

        // 4. orphan lane-1 samples
        step(1'b1, 16'd5, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'd6, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("t4_count", 32'(col_count), 32'd1);
        chk("t4_orphan", col_data_out, 32'h0000_0005);
        chk("t4_perr", 32'(col_pair_err), 32'd1);
        step(1'b0, 16'h0, 1'b1, 16'h0020, 1'b0, 1'b0);
        chk("t4_count2", 32'(col_count), 32'd2);
        idle(1'b1);
        chk("t4_pair", col_data_out, 32'h0020_0006);
        idle(1'b1);
        chk("t4_drained", 32'(col_valid_out), 32'd0);
        chk("t4_perr_sticky", 32'(col_pair_err), 32'd1);

        // 5. lone lane 2, then simultaneous lanes from EMPTY
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("t5_perr_cleared", 32'(col_pair_err), 32'd0);
        step(1'b0, 16'h0, 1'b1, 16'h0033, 1'b0, 1'b0);
        chk("t5_lone", col_data_out, 32'h0033_0000);
        chk("t5_perr", 32'(col_pair_err), 32'd1);
        step(1'b1, 16'd7, 1'b1, 16'd8, 1'b1, 1'b0);
        chk("t5_simul", col_data_out, 32'h0008_0007);
        chk("t5_count", 32'(col_count), 32'd1);
        idle(1'b1);
        chk("t5_drained", 32'(col_valid_out), 32'd0);

        // 6. clear, then reset, with data stored, slot held and inputs active
        for (int pass = 0; pass < 2; pass++) begin
            string tg;
            tg = (pass == 0) ? "t6_clear" : "t6_rst";
            for (int i = 0; i < 3; i++) begin
                step(1'b1, 16'(i), 1'b1, 16'(i + 8), 1'b0, 1'b0);
            end
            step(1'b0, 16'h0, 1'b1, 16'h0055, 1'b0, 1'b0);
            step(1'b1, 16'h0077, 1'b0, 16'h0, 1'b0, 1'b0);
            chk({tg, "_pre_count"}, 32'(col_count), 32'd4);
            chk({tg, "_pre_perr"}, 32'(col_pair_err), 32'd1);
            if (pass == 0) begin
                step(1'b1, 16'h0011, 1'b1, 16'h0022, 1'b1, 1'b1);
            end else begin
                rst = 1'b1;
                step(1'b1, 16'h0011, 1'b1, 16'h0022, 1'b1, 1'b0);
                rst = 1'b0;
            end
            chk_empty(tg);
            step(1'b0, 16'h0, 1'b1, 16'h0044, 1'b0, 1'b0);
            chk({tg, "_slot_empty"}, col_data_out, 32'h0044_0000);
            idle(1'b1);
            idle(1'b1);
            chk({tg, "_drained"}, 32'(col_valid_out), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
